// File: rtl/mc_maindec.sv
// Multicycle main controller (Moore FSM) for the 16-bit RISC CPU.
// Optional memory-wait handshake with timeout is enabled by defining MC_MAINDEC_WAIT_EN.
module mc_maindec #(
  parameter int OPW      = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output logic           pcwrite,
  output logic           branch,
  output logic           irwrite,
  output logic           memwrite,
  output logic           regwrite,
  output logic           iord,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     aluop,
  output logic [1:0]     pcsrc,
  output logic           memtoreg,
  output logic           regdst,
  output logic           link,
  output logic           instr_done,
  output logic           illegal_op,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    IMMEX   = 4'd8,
    IMMWB   = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11,
    JALWB   = 4'd12,
    ILLEGAL = 4'd13
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       memtoreg;
    logic       regdst;
    logic       link;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
  localparam logic [OPW-1:0] OP_LW    = OPW'(1);
  localparam logic [OPW-1:0] OP_SW    = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUBI  = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(5);
  localparam logic [OPW-1:0] OP_J     = OPW'(6);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(7);

  state_t state_reg, state_next;
  ctrl_t  ctrl_reg, ctrl_next;
  // Low from reset until the first rising edge: that edge enters FETCH with its strobes.
  logic   run_reg;
  logic   hold;
  logic   timeout;

`ifdef MC_MAINDEC_WAIT_EN
  logic [7:0] wait_cnt_reg, wait_cnt_next;

  always_comb begin
    hold    = run_reg && (state_reg inside {FETCH, MEMRD, MEMWR}) && !mem_ready;
    timeout = hold && (({1'b0, wait_cnt_reg} + 9'd1) >= 9'(WAIT_MAX));
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!run_reg || (state_next != state_reg)) begin
      wait_cnt_next = 8'd0;
    end else if (hold) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end
`else
  logic unused_cfg;
  assign hold       = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = ^{mem_ready, 8'(WAIT_MAX)};
`endif

  always_comb begin
    state_next = state_reg;
    if (!run_reg) begin
      state_next = FETCH;
    end else if (timeout) begin
      state_next = ILLEGAL;
    end else if (!hold) begin
      case (state_reg)
        FETCH:  state_next = DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW:     state_next = MEMADR;
            OP_RTYPE:         state_next = EXEC;
            OP_ADDI, OP_SUBI: state_next = IMMEX;
            OP_BEQ:           state_next = BRANCH;
            OP_J:             state_next = JUMP;
            OP_JAL:           state_next = JALWB;
            default:          state_next = ILLEGAL;
          endcase
        end
        MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
        MEMRD:   state_next = MEMWB;
        EXEC:    state_next = ALUWB;
        IMMEX:   state_next = IMMWB;
        default: state_next = FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state being entered so they register alongside it.
  always_comb begin
    ctrl_next = '0;
    case (state_next)
      FETCH: begin
        ctrl_next.irwrite = 1'b1;
        ctrl_next.pcwrite = 1'b1;
        ctrl_next.alusrcb = 2'b01;
      end
      DECODE: ctrl_next.alusrcb = 2'b11;
      MEMADR: begin
        ctrl_next.alusrca = 1'b1;
        ctrl_next.alusrcb = 2'b10;
      end
      MEMRD: ctrl_next.iord = 1'b1;
      MEMWB: begin
        ctrl_next.memtoreg   = 1'b1;
        ctrl_next.regwrite   = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl_next.iord       = 1'b1;
        ctrl_next.memwrite   = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      EXEC: begin
        ctrl_next.alusrca = 1'b1;
        ctrl_next.aluop   = 2'b10;
      end
      ALUWB: begin
        ctrl_next.regdst     = 1'b1;
        ctrl_next.regwrite   = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      IMMEX: begin
        ctrl_next.alusrca = 1'b1;
        ctrl_next.alusrcb = 2'b10;
        ctrl_next.aluop   = (op == OP_SUBI) ? 2'b01 : 2'b00;
      end
      IMMWB: begin
        ctrl_next.regwrite   = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl_next.alusrca    = 1'b1;
        ctrl_next.aluop      = 2'b01;
        ctrl_next.pcsrc      = 2'b01;
        ctrl_next.branch     = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl_next.pcsrc      = 2'b10;
        ctrl_next.pcwrite    = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      JALWB: begin
        ctrl_next.pcsrc      = 2'b10;
        ctrl_next.pcwrite    = 1'b1;
        ctrl_next.regwrite   = 1'b1;
        ctrl_next.link       = 1'b1;
        ctrl_next.instr_done = 1'b1;
      end
      ILLEGAL: ctrl_next.illegal_op = 1'b1;
      default: ctrl_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= FETCH;
      ctrl_reg     <= '0;
      run_reg      <= 1'b0;
`ifdef MC_MAINDEC_WAIT_EN
      wait_cnt_reg <= 8'd0;
`endif
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      run_reg      <= 1'b1;
`ifdef MC_MAINDEC_WAIT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
    end
  end

  assign pcwrite    = ctrl_reg.pcwrite;
  assign branch     = ctrl_reg.branch;
  assign irwrite    = ctrl_reg.irwrite;
  assign memwrite   = ctrl_reg.memwrite;
  assign regwrite   = ctrl_reg.regwrite;
  assign iord       = ctrl_reg.iord;
  assign alusrca    = ctrl_reg.alusrca;
  assign alusrcb    = ctrl_reg.alusrcb;
  assign aluop      = ctrl_reg.aluop;
  assign pcsrc      = ctrl_reg.pcsrc;
  assign memtoreg   = ctrl_reg.memtoreg;
  assign regdst     = ctrl_reg.regdst;
  assign link       = ctrl_reg.link;
  assign instr_done = ctrl_reg.instr_done;
  assign illegal_op = ctrl_reg.illegal_op;
  assign state      = state_reg;

endmodule
